// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous RAM.
// Grant is registered (access one cycle after arbitration); read data returns one cycle after access.
module mem_port_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_mode,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  cmd_t cmd;
  logic last_l;            // 1 = L won the most recent grant
  logic c_rv, l_rv;
  logic elig_c, elig_l, win_c, win_l;

  // A port is excluded in its own grant cycle, capping each port at one grant per two cycles.
  always_comb begin
    elig_c = c_req & ~load_mode & ~c_gnt;
    elig_l = l_req & ~l_gnt;
    win_c  = elig_c & (~elig_l | last_l);
    win_l  = elig_l & ~win_c;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      c_gnt  <= 1'b0;
      l_gnt  <= 1'b0;
      c_rv   <= 1'b0;
      l_rv   <= 1'b0;
      cmd    <= '0;
      last_l <= 1'b1;
    end else begin
      c_gnt <= win_c;
      l_gnt <= win_l;
      c_rv  <= c_gnt & ~cmd.we;
      l_rv  <= l_gnt & ~cmd.we;
      if (win_c) begin
        cmd    <= '{we: c_we, addr: c_addr, wdata: c_wdata};
        last_l <= 1'b0;
      end else if (win_l) begin
        cmd    <= '{we: l_we, addr: l_addr, wdata: l_wdata};
        last_l <= 1'b1;
      end
    end
  end

  // Address/data hold the last captured command while idle.
  assign mem_en    = c_gnt | l_gnt;
  assign mem_we    = mem_en & cmd.we;
  assign mem_addr  = cmd.addr;
  assign mem_wdata = cmd.wdata;

  assign c_rvalid = c_rv;
  assign l_rvalid = l_rv;
  assign c_rdata  = c_rv ? mem_rdata : '0;
  assign l_rdata  = l_rv ? mem_rdata : '0;
  assign busy     = c_gnt | l_gnt | c_rv | l_rv;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed scenarios plus a randomized run checked against a transaction-level model of the arbiter.
module tb_mem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clock = 1'b0;
  logic reset, load_mode;
  logic c_req, c_we, l_req, l_we;
  logic [AW-1:0] c_addr, l_addr, mem_addr;
  logic [DW-1:0] c_wdata, l_wdata, mem_wdata, mem_rdata, c_rdata, l_rdata;
  logic c_gnt, c_rvalid, l_gnt, l_rvalid, mem_en, mem_we, busy;

  logic [DW-1:0] ram     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .load_mode(load_mode),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // RAM macro: synchronous write, registered read data.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  task automatic idle_inputs();
    load_mode = 0; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    l_req = 0; l_we = 0; l_addr = '0; l_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clock);
    reset = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    @(negedge clock);
    n_cmp++; if (c_gnt !== 1'b0 || l_gnt !== 1'b0) begin n_err++; $display("FAIL reset_gnt: got c=%b l=%b expected 0 0", c_gnt, l_gnt); end
    n_cmp++; if (c_rvalid !== 1'b0 || l_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got c=%b l=%b expected 0 0", c_rvalid, l_rvalid); end
    n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reset_mem: got en=%b we=%b busy=%b expected 0 0 0", mem_en, mem_we, busy); end
    n_cmp++; if (mem_addr !== '0 || mem_wdata !== '0) begin n_err++; $display("FAIL reset_cmd: got addr=%h wdata=%h expected 0 0", mem_addr, mem_wdata); end
    reset = 0;
    @(negedge clock);
  endtask

  task automatic test_single_read();
    ram[12'h010] = 16'h1234;
    l_req = 1; l_we = 0; l_addr = 12'h010;
    @(negedge clock);
    n_cmp++; if (l_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 12'h010) begin n_err++; $display("FAIL read_access: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 010", l_gnt, mem_en, mem_we, mem_addr); end
    n_cmp++; if (c_gnt !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL read_cgnt_busy: got c_gnt=%b busy=%b expected 0 1", c_gnt, busy); end
    l_req = 0;
    @(negedge clock);
    n_cmp++; if (l_rvalid !== 1'b1 || l_rdata !== 16'h1234 || l_gnt !== 1'b0) begin n_err++; $display("FAIL read_return: got rv=%b data=%h gnt=%b expected 1 1234 0", l_rvalid, l_rdata, l_gnt); end
    n_cmp++; if (c_rvalid !== 1'b0 || c_rdata !== '0 || c_gnt !== 1'b0) begin n_err++; $display("FAIL read_c_quiet: got rv=%b data=%h gnt=%b expected 0 0000 0", c_rvalid, c_rdata, c_gnt); end
    @(negedge clock);
  endtask

  task automatic test_tie();
    idle_inputs();
    reset = 1;
    @(negedge clock);
    c_req = 1; c_addr = 12'h100; l_req = 1; l_addr = 12'h200;
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_cmp++;
      if (c_gnt !== (i % 2 == 0) || l_gnt !== (i % 2 == 1)) begin
        n_err++; $display("FAIL tie_order[%0d]: got c=%b l=%b expected c=%0d l=%0d", i, c_gnt, l_gnt, (i % 2 == 0), (i % 2 == 1));
      end
    end
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  task automatic test_write();
    int rv_seen;
    c_req = 1; c_we = 1; c_addr = 12'h005; c_wdata = 16'hBEEF;
    @(negedge clock);
    n_cmp++; if (c_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 16'hBEEF) begin n_err++; $display("FAIL write_access: got gnt=%b we=%b addr=%h wdata=%h expected 1 1 005 beef", c_gnt, mem_we, mem_addr, mem_wdata); end
    idle_inputs();
    rv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (c_rvalid !== 1'b0) rv_seen++;
      if (i == 0) begin
        n_cmp++; if (mem_en !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 12'h005 || c_gnt !== 1'b0) begin n_err++; $display("FAIL write_idle_hold: got en=%b we=%b addr=%h gnt=%b expected 0 0 005 0", mem_en, mem_we, mem_addr, c_gnt); end
      end
    end
    n_cmp++; if (rv_seen != 0) begin n_err++; $display("FAIL write_no_rvalid: got %0d rvalid cycles expected 0", rv_seen); end
    l_req = 1; l_we = 0; l_addr = 12'h005;
    @(negedge clock);
    l_req = 0;
    @(negedge clock);
    n_cmp++; if (l_rvalid !== 1'b1 || l_rdata !== 16'hBEEF) begin n_err++; $display("FAIL write_readback: got rv=%b data=%h expected 1 beef", l_rvalid, l_rdata); end
    @(negedge clock);
  endtask

  task automatic test_load_fence();
    int cg, lg, waited;
    bit got;
    load_mode = 1;
    c_req = 1; c_we = 1; c_addr = 12'h0C3; c_wdata = 16'h5A5A;
    l_req = 1; l_we = 0; l_addr = 12'h020;
    cg = 0; lg = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      cg += int'(c_gnt); lg += int'(l_gnt);
    end
    n_cmp++; if (cg != 0 || lg != 3) begin n_err++; $display("FAIL fence_window: got c_grants=%0d l_grants=%0d expected 0 3", cg, lg); end
    load_mode = 0; l_req = 0;
    got = 0; waited = 0;
    while (!got && waited < 2) begin
      @(negedge clock);
      waited++;
      if (c_gnt === 1'b1) begin
        got = 1;
        n_cmp++; if (mem_we !== 1'b1 || mem_addr !== 12'h0C3 || mem_wdata !== 16'h5A5A) begin n_err++; $display("FAIL fence_cmd: got we=%b addr=%h wdata=%h expected 1 0c3 5a5a", mem_we, mem_addr, mem_wdata); end
      end
    end
    n_cmp++; if (!got) begin n_err++; $display("FAIL fence_release: got no c_gnt within %0d cycles expected a grant", waited); end
    idle_inputs();
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_mid_read();
    ram[12'h033] = 16'h7777;
    l_req = 1; l_we = 0; l_addr = 12'h033;
    @(negedge clock);
    n_cmp++; if (l_gnt !== 1'b1) begin n_err++; $display("FAIL rst_mid_gnt: got %b expected 1", l_gnt); end
    reset = 1;
    @(negedge clock);
    reset = 0;
    n_cmp++; if (l_rvalid !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0 || l_gnt !== 1'b0) begin n_err++; $display("FAIL rst_mid_discard: got rv=%b busy=%b en=%b gnt=%b expected 0 0 0 0", l_rvalid, busy, mem_en, l_gnt); end
    @(negedge clock);
    n_cmp++; if (l_gnt !== 1'b1 || l_rvalid !== 1'b0 || mem_addr !== 12'h033) begin n_err++; $display("FAIL rst_mid_regrant: got gnt=%b rv=%b addr=%h expected 1 0 033", l_gnt, l_rvalid, mem_addr); end
    l_req = 0;
    @(negedge clock);
    n_cmp++; if (l_rvalid !== 1'b1 || l_rdata !== 16'h7777) begin n_err++; $display("FAIL rst_mid_return: got rv=%b data=%h expected 1 7777", l_rvalid, l_rdata); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    ram[12'h001] = 16'h0AAA; ram[12'h002] = 16'h0BBB;
    c_req = 1; c_we = 0; c_addr = 12'h001;
    @(negedge clock);
    n_cmp++; if (c_gnt !== 1'b1 || l_gnt !== 1'b0) begin n_err++; $display("FAIL b2b_cgnt: got c=%b l=%b expected 1 0", c_gnt, l_gnt); end
    c_req = 0;
    l_req = 1; l_we = 0; l_addr = 12'h002;
    @(negedge clock);
    l_req = 0;
    n_cmp++; if (l_gnt !== 1'b1 || c_rvalid !== 1'b1 || c_rdata !== 16'h0AAA || l_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_c_return: got lgnt=%b crv=%b cdata=%h lrv=%b expected 1 1 0aaa 0", l_gnt, c_rvalid, c_rdata, l_rvalid); end
    @(negedge clock);
    n_cmp++; if (l_rvalid !== 1'b1 || l_rdata !== 16'h0BBB || c_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_l_return: got lrv=%b ldata=%h crv=%b expected 1 0bbb 0", l_rvalid, l_rdata, c_rvalid); end
    @(negedge clock);
  endtask

  // Transaction-level model: which port owns the RAM this cycle, what it does, and which port
  // is owed data next cycle.
  task automatic test_random();
    typedef enum int {NONE, PORT_C, PORT_L} port_e;
    port_e owner, last_winner, returning;
    bit            o_we;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata, ret_data;
    bit            c_pend, l_pend;
    idle_inputs();
    do_reset();
    for (int i = 0; i < 4096; i++) ref_mem[i] = ram[i];
    owner = NONE; last_winner = PORT_L; returning = NONE;
    o_we = 0; o_addr = '0; o_wdata = '0; ret_data = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      n_cmp++; if (c_gnt !== (owner == PORT_C) || l_gnt !== (owner == PORT_L)) begin n_err++; $display("FAIL rnd_gnt@%0d: got c=%b l=%b expected c=%0d l=%0d", cyc, c_gnt, l_gnt, owner == PORT_C, owner == PORT_L); end
      n_cmp++; if (mem_en !== (owner != NONE) || mem_we !== (owner != NONE && o_we)) begin n_err++; $display("FAIL rnd_en@%0d: got en=%b we=%b expected %0d %0d", cyc, mem_en, mem_we, owner != NONE, owner != NONE && o_we); end
      n_cmp++; if (mem_addr !== o_addr || mem_wdata !== o_wdata) begin n_err++; $display("FAIL rnd_cmd@%0d: got addr=%h wdata=%h expected %h %h", cyc, mem_addr, mem_wdata, o_addr, o_wdata); end
      n_cmp++; if (c_rvalid !== (returning == PORT_C) || l_rvalid !== (returning == PORT_L)) begin n_err++; $display("FAIL rnd_rvalid@%0d: got c=%b l=%b expected c=%0d l=%0d", cyc, c_rvalid, l_rvalid, returning == PORT_C, returning == PORT_L); end
      n_cmp++; if (c_rdata !== (returning == PORT_C ? ret_data : '0) || l_rdata !== (returning == PORT_L ? ret_data : '0)) begin n_err++; $display("FAIL rnd_rdata@%0d: got c=%h l=%h expected data %h to port %0d", cyc, c_rdata, l_rdata, ret_data, returning); end
      if (owner != NONE) begin
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rnd_busy@%0d: got %b expected 1", cyc, busy); end
      end else if (returning == NONE) begin
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rnd_idle@%0d: got %b expected 0", cyc, busy); end
      end
      // requesters react to this cycle's grant, then present the next command
      if (c_req && owner == PORT_C) c_req = $urandom_range(0, 1);
      else if (!c_req) c_req = ($urandom_range(0, 2) == 0);
      if (c_req && (owner == PORT_C || !c_pend)) begin c_we = $urandom_range(0, 1); c_addr = AW'($urandom_range(0, 15)); c_wdata = DW'($urandom); end
      if (l_req && owner == PORT_L) l_req = $urandom_range(0, 1);
      else if (!l_req) l_req = ($urandom_range(0, 2) == 0);
      if (l_req && (owner == PORT_L || !l_pend)) begin l_we = $urandom_range(0, 1); l_addr = AW'($urandom_range(0, 15)); l_wdata = DW'($urandom); end
      if ($urandom_range(0, 7) == 0) load_mode = ~load_mode;
      c_pend = c_req; l_pend = l_req;
      // this cycle's access, and who is owed read data next cycle
      returning = NONE;
      if (owner != NONE) begin
        if (o_we) ref_mem[o_addr] = o_wdata;
        else begin ret_data = ref_mem[o_addr]; returning = owner; end
      end
      // arbitration for next cycle: the current owner sits out; ties go to the other port than last time
      begin
        bit want_c, want_l;
        port_e nxt;
        want_c = c_req && !load_mode && owner != PORT_C;
        want_l = l_req && owner != PORT_L;
        if (want_c && want_l) nxt = (last_winner == PORT_C) ? PORT_L : PORT_C;
        else if (want_c) nxt = PORT_C;
        else if (want_l) nxt = PORT_L;
        else nxt = NONE;
        if (nxt == PORT_C) begin o_we = c_we; o_addr = c_addr; o_wdata = c_wdata; end
        if (nxt == PORT_L) begin o_we = l_we; o_addr = l_addr; o_wdata = l_wdata; end
        if (nxt != NONE) last_winner = nxt;
        owner = nxt;
      end
      @(negedge clock);
    end
    idle_inputs();
    repeat (3) @(negedge clock);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = DW'($urandom);
    reset = 1;
    idle_inputs();
    @(negedge clock);
    test_reset();
    test_single_read();
    test_tie();
    test_write();
    test_load_fence();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port synchronous program/data RAM between two requesters:
  - the CPU control path (port C: fetch, load, store);
  - the program loader/debug reader (port L).
- Registered round-robin arbitration with a request/grant handshake and a fixed read-return latency.
- A load_mode input fences the CPU out while a program image is written.
- Sits between the control unit/datapath, the loader and the RAM macro.

Parameters:
ADDR_W, 12, RAM address width
DATA_W, 16, RAM data width

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
load_mode  in  1  1 = port C requests ignored (loader owns RAM)
c_req  in  1  CPU request; held with command stable until c_gnt seen
c_we  in  1  CPU write enable (1 = store, 0 = read)
c_addr  in  ADDR_W  CPU address
c_wdata  in  DATA_W  CPU write data
c_gnt  out  1  one-cycle grant; RAM access performed this cycle
c_rvalid  out  1  CPU read data valid (one cycle)
c_rdata  out  DATA_W  CPU read data
l_req, l_we, l_addr, l_wdata  in  1/1/ADDR_W/DATA_W  loader request, same rules as port C
l_gnt, l_rvalid, l_rdata  out  1/1/DATA_W  loader grant, read valid, read data
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we = 0
busy  out  1  1 while a grant or read return is in flight

Behaviour:
- Cycle N (arbitrate):
  - eligible_C = c_req & ~load_mode & ~c_gnt; eligible_L = l_req & ~l_gnt.
  - The currently granted port is excluded from arbitration in its grant cycle.
  - Winner's command (we, addr, wdata) is captured into registers.
- Cycle N+1 (access):
  - Winner's gnt = 1 for exactly one cycle.
  - mem_en = 1; mem_we/mem_addr/mem_wdata driven from the captured registers.
  - Requester drops req or presents its next command after seeing gnt.
- Cycle N+2 (return, reads only):
  - Winner's rvalid = 1; its rdata = mem_rdata.
  - No rvalid for writes.
  - Loser's rdata is don't-care and is driven 0.
- Tie-break (both eligible): the port not granted most recently wins. A last-winner register updates on every grant.
- Single eligible port: it wins regardless of the last-winner register.
- Throughput:
  - Each port gets at most one grant per 2 cycles.
  - Alternating C/L requests may be granted on consecutive cycles.
  - Read returns then overlap the next access; this is legal because each return belongs to a distinct port.
- load_mode:
  - Sampled only at arbitration.
  - A C grant already issued completes, including its rvalid.
  - No new C grant is issued while load_mode = 1.
  - c_req stays pending and is served after load_mode falls.
- Outputs idle (mem_en = 0, all gnt = 0): mem_we = 0, mem_addr and mem_wdata hold their last value.
- busy = any gnt registered, or any rvalid pending for the next cycle.
- Reset (synchronous, takes priority over all other logic):
  - All gnt, rvalid, mem_en, mem_we and busy = 0 the cycle after reset is sampled high.
  - Captured command registers = 0.
  - Last-winner register = L, so C wins the first tie.
  - A grant or read in flight at reset is discarded: no gnt or rvalid is issued for it after reset.
  - Requests still held high when reset falls are arbitrated normally.
- Sticky protocol rule: a requester must not change we/addr/wdata while req = 1 and gnt = 0. The arbiter does not check this.

Test Plan:
1. Single read: l_req = 1, l_we = 0, l_addr = 0x010, RAM[0x010] = 0x1234 → l_gnt high at N+1 with mem_en = 1 and mem_addr = 0x010; l_rvalid = 1 and l_rdata = 0x1234 at N+2; c_gnt stays 0.
2. Tie after reset: c_req and l_req both high at the first cycle after reset → grant order C, L, C, L on consecutive cycles, no port granted twice in a row while both requests are held.
3. Write: c_req = 1, c_we = 1, c_addr = 0x005, c_wdata = 0xBEEF → one cycle with c_gnt = 1, mem_we = 1, mem_addr = 0x005, mem_wdata = 0xBEEF; c_rvalid never asserted; a subsequent L read of 0x005 returns 0xBEEF.
4. load_mode fence:
   - Setup: load_mode = 1; c_req and l_req held high for 6 cycles.
   - Required: only L grants during that window.
   - Then load_mode drops to 0: c_gnt within 2 cycles; the pending C command executes unchanged.
5. Reset mid-read: reset = 1 in the cycle an L read is granted → no l_rvalid afterwards; busy = 0 and mem_en = 0 the next cycle; after release, a held l_req is granted again and returns correct data.
6. Back-to-back mixed: C read 0x001 (data 0x0AAA) at N, L read 0x002 (data 0x0BBB) at N+1 → c_rvalid/0x0AAA at N+2 and l_rvalid/0x0BBB at N+3; neither rvalid is asserted on the wrong port.
